// File: rtl/noc_port_arbiter_if.sv
// Handshake bundle between the competing VC requesters and the output-port
// arbiter. The arbiter side uses the slave modport; the requesters use master.
interface noc_port_arbiter_if #(
  parameter int unsigned Noc_VC_Channel = 4,
  parameter int unsigned CHANNELS       = Noc_VC_Channel
) ();
  logic [CHANNELS-1:0] request;
  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] start_of_packet;
  logic [CHANNELS-1:0] end_of_packet;
  logic [CHANNELS-1:0] grant;
  logic                locked;
  logic                proto_err;

  modport master (
    output request,
    output free,
    output start_of_packet,
    output end_of_packet,
    input  grant,
    input  locked,
    input  proto_err
  );

  modport slave (
    input  request,
    input  free,
    input  start_of_packet,
    input  end_of_packet,
    output grant,
    output locked,
    output proto_err
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Packet-locked round-robin arbiter for one NoC output port.
// A VC wins only with a header flit and keeps the port until its own tail.
// Optional feature: define NOC_ARB_BACK_TO_BACK_EN to hand the port straight
// to the next header in the owner's tail cycle (no idle bubble).
module noc_port_arbiter #(
  parameter int unsigned Noc_VC_Channel = 4,
  parameter int unsigned CHANNELS       = Noc_VC_Channel
) (
  input logic               noc_clk,
  input logic               noc_rst_n,
  noc_port_arbiter_if.slave port_if
);

  localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  idx_t                owner_q, owner_d;
  idx_t                last_q, last_d;
  logic                err_q, err_d;

  logic [CHANNELS-1:0] eligible;
  logic                owner_eop;

  // Increment with wrap from CHANNELS-1 back to 0.
  function automatic idx_t next_idx(input idx_t i);
    if (32'(i) >= CHANNELS - 1) begin
      return '0;
    end
    return i + idx_t'(1);
  endfunction

  // First set bit of elig scanning upward from start, wrapping.
  function automatic idx_t rr_pick(input logic [CHANNELS-1:0] elig, input idx_t start);
    idx_t cand;
    idx_t win;
    logic found;
    cand  = start;
    win   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = next_idx(cand);
    end
    return win;
  endfunction

  function automatic logic [CHANNELS-1:0] to_onehot(input idx_t i);
    logic [CHANNELS-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  assign eligible  = port_if.request & port_if.start_of_packet;
  assign owner_eop = port_if.end_of_packet[owner_q];

`ifdef NOC_ARB_BACK_TO_BACK_EN
  logic [CHANNELS-1:0] btb_elig;
  assign btb_elig = eligible & ~grant_q;
`endif

  // Flit-level flow control never influences ownership.
  logic unused_free;
  assign unused_free = ^port_if.free;

  // Next-state: arbitration in idle, hold until owner tail, protocol checks.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Any tail, or any flit that is not a header, arrives without ownership.
        err_d = (|port_if.end_of_packet) |
                (|(port_if.request & ~port_if.start_of_packet));
        if (|eligible) begin
          owner_d = rr_pick(eligible, next_idx(last_q));
          grant_d = to_onehot(owner_d);
          state_d = StLocked;
        end
      end
      StLocked: begin
        err_d = |(port_if.end_of_packet & ~grant_q);
        if (owner_eop) begin
          last_d  = owner_q;
          grant_d = '0;
          state_d = StIdle;
`ifdef NOC_ARB_BACK_TO_BACK_EN
          if (|btb_elig) begin
            owner_d = rr_pick(btb_elig, next_idx(owner_q));
            grant_d = to_onehot(owner_d);
            state_d = StLocked;
          end
`endif
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset leaves VC 0 with first priority.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= idx_t'(CHANNELS - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign port_if.grant     = grant_q;
  assign port_if.locked    = |grant_q;
  assign port_if.proto_err = err_q;

endmodule

// File: doc/noc_port_arbiter.md
NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default Noc_VC_Channel: number of competing VC requesters.
REQ-002 SHALL have port noc_clk  input  1  the single clock; all state on its rising edge.
REQ-003 SHALL have port noc_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port request  input  CHANNELS  VC i holds a valid flit routed to this port.
REQ-005 SHALL have port free  input  CHANNELS  downstream ready as seen by VC i; a flit transfers when request[i] & free[i].
REQ-006 SHALL have port start_of_packet  input  CHANNELS  VC i presents a valid header flit.
REQ-007 SHALL have port end_of_packet  input  CHANNELS  tail flit of VC i transferred this cycle.
REQ-008 SHALL have port grant  output  CHANNELS  one-hot or zero ownership of the output port.
REQ-009 SHALL have port locked  output  1  port owned by a packet (grant != 0).
REQ-010 SHALL have port proto_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-011 SHALL implement FSM states IDLE (grant = 0) and LOCKED (grant one-hot, registered).
REQ-012 In IDLE, eligible set = request & start_of_packet; if non-empty, winner chosen round-robin starting at index (last_winner+1) mod CHANNELS.
REQ-013 Winner SHALL appear on grant the cycle after the eligible cycle (1-cycle latency); FSM -> LOCKED.
REQ-014 In LOCKED, grant SHALL stay unchanged regardless of other requests until end_of_packet[owner] = 1.
REQ-015 On end_of_packet[owner], last_winner <= owner; grant clears next cycle (unless REQ-027 applies).
REQ-016 Single-flit packet: start_of_packet and end_of_packet of owner high in the same LOCKED cycle SHALL release as REQ-015.
REQ-017 end_of_packet from a non-owner, or from any VC in IDLE, SHALL be ignored for state and SHALL pulse proto_err next cycle.
REQ-018 request without start_of_packet from a non-owner VC in IDLE SHALL NOT be granted (mid-packet flit without ownership) and SHALL pulse proto_err next cycle.
REQ-019 proto_err SHALL be exactly one cycle per violating cycle; multiple simultaneous violations give one pulse.
REQ-020 free SHALL NOT affect arbitration or release; owner stalls (free = 0) extend LOCKED indefinitely.
REQ-021 last_winner width SHALL be clog2(CHANNELS) (min 1); wrap from CHANNELS-1 to 0.
REQ-022 CHANNELS = 1: grant[0] follows REQ-011..015, no rotation.
REQ-023 locked SHALL equal |grant at all times.

Reset
REQ-024 Reset assertion SHALL immediately clear grant, locked, proto_err, FSM -> IDLE, last_winner <= CHANNELS-1 (so VC 0 has first priority).
REQ-025 Reset mid-packet SHALL abandon the packet; after release, a header is required for regrant.
REQ-026 First arbitration SHALL occur on the first rising edge with noc_rst_n high.

Configuration
REQ-027 With NOC_ARB_BACK_TO_BACK_EN defined: in the owner's end_of_packet cycle, the arbiter SHALL arbitrate among eligible VCs other than the owner (pointer starting at owner+1) and load the new winner directly into grant next cycle (zero bubble); if none eligible, -> IDLE.
REQ-028 Without NOC_ARB_BACK_TO_BACK_EN: release always passes through one IDLE cycle with grant = 0 before any new grant.

Verification (CHANNELS = 4)
REQ-029 Reset release, request=4'b0110, start_of_packet=4'b0110 -> grant=4'b0010 next cycle, held until end_of_packet[1]; next grant=4'b0100.
REQ-030 Owner VC2 stalled free=0 for 10 cycles while VC0/VC3 request headers -> grant stays 4'b0100, proto_err=0.
REQ-031 All four VCs continuously send 3-flit packets -> grant order 0,1,2,3,0; with _EN no zero-grant cycle between packets, without _EN exactly one.
REQ-032 VC3 single-flit packet (SOP=EOP=1 in grant cycle) -> grant released next cycle, last_winner=3, next priority VC0.
REQ-033 end_of_packet[0] while VC1 owns; request[2]=1 with start_of_packet[2]=0 in IDLE -> proto_err one-cycle pulse each, grant unaffected.
REQ-034 noc_rst_n low mid-packet (owner VC1) -> grant=0, locked=0 immediately; after release, header from VC0 and VC1 -> grant=4'b0001.
